// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter: the arbiter state
// encoding, the requester port indices and the default memory depth.
// Ports: none (package).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } arbState_t;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    localparam int unsigned DEFAULT_MEM_WORDS = 262144;

    // Widened compare so any address width up to 64 bits can be range checked
    // against the memory depth without truncating either side.
    function automatic logic addrInRange(input logic [63:0] addr, input int unsigned words);
        return (addr < 64'(words));
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles both requester handshakes and the memory-side bus of mem_arbiter.
// Signals:
//   p0_* / p1_*  requester request, write enable, address, write data in;
//                read data, ack pulse and out-of-range error out
//   mem_*        memory write enable, address, write data out; read data in
//   busy         arbiter not idle
// Modports:
//   slave  - the arbiter side
//   master - the requester/memory environment side
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_ack;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_ack;
    logic              p1_err;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_rdata, p0_ack, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_rdata, p1_ack, p1_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_rdata, p0_ack, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_rdata, p1_ack, p1_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Purely combinational two-way round-robin pick. The last-grant history is
// kept by the caller so this block stays stateless.
// Ports:
//   i_eligible0/1  port may be granted this cycle
//   i_lastGrant    index of the most recently granted port
//   o_grantValid   some port is granted
//   o_grantIdx     granted port index (0 when nothing is eligible)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic i_eligible0,
    input  logic i_eligible1,
    input  logic i_lastGrant,
    output logic o_grantValid,
    output logic o_grantIdx
);

    // A lone eligible port always wins; on a tie the port that did not get
    // the previous grant goes next, which makes contended grants alternate.
    always_comb begin
        o_grantValid = i_eligible0 | i_eligible1;
        o_grantIdx   = PORT_IFETCH;
        if (i_eligible0 && i_eligible1) begin
            o_grantIdx = ~i_lastGrant;
        end else if (i_eligible1) begin
            o_grantIdx = PORT_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port, synchronous-read word memory between an
// instruction-fetch requester (port 0) and a load/store requester (port 1).
// One access is in flight at a time; out-of-range addresses are answered
// with an error ack without touching memory. Every output is a register.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  mem_arbiter_if.slave: both requester handshakes, memory bus, busy
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS,
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 32
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    arbState_t         r_state;
    arbState_t         w_nextState;
    logic              r_lastGrant;
    logic              w_lastGrantNext;
    logic              r_port;
    logic              w_portNext;
    logic              r_we;
    logic              w_weNext;

    logic              r_memWe;
    logic              w_memWeNext;
    logic [ADDR_W-1:0] r_memAddr;
    logic [ADDR_W-1:0] w_memAddrNext;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] w_memWdataNext;

    logic [DATA_W-1:0] r_p0Rdata;
    logic [DATA_W-1:0] w_p0RdataNext;
    logic [DATA_W-1:0] r_p1Rdata;
    logic [DATA_W-1:0] w_p1RdataNext;
    logic              r_p0Ack;
    logic              w_p0AckNext;
    logic              r_p1Ack;
    logic              w_p1AckNext;
    logic              r_p0Err;
    logic              w_p0ErrNext;
    logic              r_p1Err;
    logic              w_p1ErrNext;
    logic              r_busy;
    logic              w_busyNext;

    logic              w_inAck;
    logic              w_eligible0;
    logic              w_eligible1;
    logic              w_grantValid;
    logic              w_grantIdx;
    logic              w_grantWe;
    logic [ADDR_W-1:0] w_grantAddr;
    logic [DATA_W-1:0] w_grantWdata;
    logic              w_grantInRange;

    // While a port is being acked its req is still high (the requester only
    // drops it after seeing ack), so it must not be granted again from ACK.
    assign w_inAck     = (r_state == ACK);
    assign w_eligible0 = bus.p0_req && !(w_inAck && (r_port == PORT_IFETCH));
    assign w_eligible1 = bus.p1_req && !(w_inAck && (r_port == PORT_DATA));

    rr_arbiter2 u_rrArbiter (
        .i_eligible0  (w_eligible0),
        .i_eligible1  (w_eligible1),
        .i_lastGrant  (r_lastGrant),
        .o_grantValid (w_grantValid),
        .o_grantIdx   (w_grantIdx)
    );

    // Select the winning port's command so the FSM only deals with one set.
    assign w_grantWe      = (w_grantIdx == PORT_DATA) ? bus.p1_we    : bus.p0_we;
    assign w_grantAddr    = (w_grantIdx == PORT_DATA) ? bus.p1_addr  : bus.p0_addr;
    assign w_grantWdata   = (w_grantIdx == PORT_DATA) ? bus.p1_wdata : bus.p0_wdata;
    assign w_grantInRange = addrInRange(64'(w_grantAddr), MEM_WORDS);

    // Next-state and next-output logic. Arbitration runs in IDLE and ACK so
    // back-to-back accesses chain ACK -> ISSUE with no idle cycle. The memory
    // write strobe is a one-cycle pulse that only exists during ISSUE; acks
    // and errors are pulses that only exist during ACK. Read data is held
    // per port until that port's next ack.
    always_comb begin
        w_nextState     = r_state;
        w_lastGrantNext = r_lastGrant;
        w_portNext      = r_port;
        w_weNext        = r_we;
        w_memWeNext     = 1'b0;
        w_memAddrNext   = r_memAddr;
        w_memWdataNext  = r_memWdata;
        w_p0RdataNext   = r_p0Rdata;
        w_p1RdataNext   = r_p1Rdata;
        w_p0AckNext     = 1'b0;
        w_p1AckNext     = 1'b0;
        w_p0ErrNext     = 1'b0;
        w_p1ErrNext     = 1'b0;

        case (r_state)
            IDLE, ACK: begin
                if (w_grantValid) begin
                    w_lastGrantNext = w_grantIdx;
                    w_portNext      = w_grantIdx;
                    w_weNext        = w_grantWe;
                    if (w_grantInRange) begin
                        w_memAddrNext  = w_grantAddr;
                        w_memWdataNext = w_grantWdata;
                        w_memWeNext    = w_grantWe;
                        w_nextState    = ISSUE;
                    end else begin
                        w_nextState = ACK;
                        if (w_grantIdx == PORT_DATA) begin
                            w_p1AckNext   = 1'b1;
                            w_p1ErrNext   = 1'b1;
                            w_p1RdataNext = '0;
                        end else begin
                            w_p0AckNext   = 1'b1;
                            w_p0ErrNext   = 1'b1;
                            w_p0RdataNext = '0;
                        end
                    end
                end else begin
                    w_nextState = IDLE;
                end
            end
            ISSUE: begin
                w_nextState = CAPTURE;
            end
            CAPTURE: begin
                w_nextState = ACK;
                if (r_port == PORT_DATA) begin
                    w_p1AckNext = 1'b1;
                    if (!r_we) begin
                        w_p1RdataNext = bus.mem_rdata;
                    end
                end else begin
                    w_p0AckNext = 1'b1;
                    if (!r_we) begin
                        w_p0RdataNext = bus.mem_rdata;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        w_busyNext = (w_nextState != IDLE);
    end

    // State and output registers. Reset aborts any access in flight; the
    // last-grant history resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lastGrant <= PORT_DATA;
            r_port      <= PORT_IFETCH;
            r_we        <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_p0Rdata   <= '0;
            r_p1Rdata   <= '0;
            r_p0Ack     <= 1'b0;
            r_p1Ack     <= 1'b0;
            r_p0Err     <= 1'b0;
            r_p1Err     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_lastGrant <= w_lastGrantNext;
            r_port      <= w_portNext;
            r_we        <= w_weNext;
            r_memWe     <= w_memWeNext;
            r_memAddr   <= w_memAddrNext;
            r_memWdata  <= w_memWdataNext;
            r_p0Rdata   <= w_p0RdataNext;
            r_p1Rdata   <= w_p1RdataNext;
            r_p0Ack     <= w_p0AckNext;
            r_p1Ack     <= w_p1AckNext;
            r_p0Err     <= w_p0ErrNext;
            r_p1Err     <= w_p1ErrNext;
            r_busy      <= w_busyNext;
        end
    end

    assign bus.mem_we    = r_memWe;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.p0_rdata  = r_p0Rdata;
    assign bus.p0_ack    = r_p0Ack;
    assign bus.p0_err    = r_p0Err;
    assign bus.p1_rdata  = r_p1Rdata;
    assign bus.p1_ack    = r_p1Ack;
    assign bus.p1_err    = r_p1Err;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Requests push their expected response
// (read data, error flag, ack cycle) into a per-port queue; a monitor pops
// and compares whenever the arbiter raises an ack. A small synchronous-read
// memory model sits on the memory bus.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int unsigned WORDS = 262144;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          ackCycle;
    } expect_t;

    logic clk;
    logic rst;
    int   cycleCount;
    int   checks;
    int   failures;
    int   weCount;

    expect_t exp0Q[$];
    expect_t exp1Q[$];

    logic [31:0] memModel [0:WORDS-1];

    mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_arbiter #(
        .MEM_WORDS (WORDS),
        .DATA_W    (32),
        .ADDR_W    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Synchronous-read memory: data for the address seen at an edge appears
    // after that edge, and a write lands at the edge where mem_we is high.
    always @(posedge clk) begin
        if (bus.mem_we && (bus.mem_addr < WORDS)) begin
            memModel[bus.mem_addr[17:0]] <= bus.mem_wdata;
        end
        bus.mem_rdata <= (bus.mem_addr < WORDS) ? memModel[bus.mem_addr[17:0]] : 32'h0;
    end

    // Count cycles in which the memory sees a write strobe.
    always @(negedge clk) begin
        if (!rst && bus.mem_we) weCount++;
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation for a port and compare it with the ack.
    task automatic checkOutput(input bit port);
        expect_t e;
        if ((port ? exp1Q.size() : exp0Q.size()) == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_ack_p%0d: got ack with no request outstanding at cycle %0d", port, cycleCount);
        end else if (port) begin
            e = exp1Q.pop_front();
            checkValue("p1_rdata", bus.p1_rdata, e.rdata);
            checkValue("p1_err", 32'(bus.p1_err), 32'(e.err));
            checkValue("p1_ack_cycle", 32'(cycleCount), 32'(e.ackCycle));
        end else begin
            e = exp0Q.pop_front();
            checkValue("p0_rdata", bus.p0_rdata, e.rdata);
            checkValue("p0_err", 32'(bus.p0_err), 32'(e.err));
            checkValue("p0_ack_cycle", 32'(cycleCount), 32'(e.ackCycle));
        end
    endtask

    // Monitor: acks are sampled half a cycle after the edge that raised them.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.p0_ack) checkOutput(1'b0);
            if (bus.p1_ack) checkOutput(1'b1);
        end
    end

    // Issue one request from a negedge, record what the response must be,
    // hold the request until ack, then drop it.
    task automatic applyStimulus(input bit port, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRdata,
                                 input bit expErr, input int latency);
        expect_t e;
        bit      seen;
        e.rdata    = expRdata;
        e.err      = expErr;
        e.ackCycle = cycleCount + latency;
        seen       = 1'b0;
        if (port) begin
            exp1Q.push_back(e);
            bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
        end else begin
            exp0Q.push_back(e);
            bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (port ? bus.p1_ack : bus.p0_ack) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL ack_timeout_p%0d: got no ack within 60 cycles for addr 0x%08h", port, addr);
        end
        if (port) bus.p1_req = 1'b0;
        else      bus.p0_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) memModel[i] = 32'h0;
        memModel[4] = 32'h1111_0004;
        memModel[8] = 32'h2222_0008;
    end

    initial begin
        checks = 0; failures = 0; weCount = 0; cycleCount = 0;
        rst = 1'b1;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;

        #1;
        checkValue("reset_mem_we", 32'(bus.mem_we), 32'h0);
        checkValue("reset_mem_addr", bus.mem_addr, 32'h0);
        checkValue("reset_p0_ack", 32'(bus.p0_ack), 32'h0);
        checkValue("reset_p1_ack", 32'(bus.p1_ack), 32'h0);
        checkValue("reset_busy", 32'(bus.busy), 32'h0);
        checkValue("reset_p0_rdata", bus.p0_rdata, 32'h0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] simultaneous reads, port 0 wins the first tie");
        fork
            applyStimulus(1'b0, 1'b0, 32'h4, 32'h0, 32'h1111_0004, 1'b0, 3);
            applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 32'h2222_0008, 1'b0, 6);
        join
        @(negedge clk);

        $display("[TB] sustained contention, grants alternate 0,1,0,1,0,1");
        fork
            begin
                applyStimulus(1'b0, 1'b0, 32'h4, 32'h0, 32'h1111_0004, 1'b0, 3);
                applyStimulus(1'b0, 1'b0, 32'h4, 32'h0, 32'h1111_0004, 1'b0, 6);
                applyStimulus(1'b0, 1'b0, 32'h4, 32'h0, 32'h1111_0004, 1'b0, 6);
            end
            begin
                applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 32'h2222_0008, 1'b0, 6);
                applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 32'h2222_0008, 1'b0, 6);
                applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 32'h2222_0008, 1'b0, 6);
            end
        join
        @(negedge clk);

        $display("[TB] port 1 write then port 0 read back");
        weCount = 0;
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h2222_0008, 1'b0, 3);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
        checkValue("write_strobe_cycles", 32'(weCount), 32'd1);
        @(negedge clk);

        $display("[TB] port 0 read at first out-of-range address");
        applyStimulus(1'b0, 1'b0, 32'h0004_0000, 32'h0, 32'h0, 1'b1, 1);
        checkValue("oor_mem_addr_held", bus.mem_addr, 32'h10);
        checkValue("oor_no_write_strobe", 32'(weCount), 32'd1);
        @(negedge clk);

        $display("[TB] reset during capture of a port 1 read");
        bus.p1_we = 1'b0; bus.p1_addr = 32'h8; bus.p1_wdata = 32'h1234_5678; bus.p1_req = 1'b1;
        repeat (2) @(negedge clk);
        checkValue("busy_before_reset", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        #1;
        checkValue("midrst_mem_we", 32'(bus.mem_we), 32'h0);
        checkValue("midrst_mem_addr", bus.mem_addr, 32'h0);
        checkValue("midrst_mem_wdata", bus.mem_wdata, 32'h0);
        checkValue("midrst_p0_rdata", bus.p0_rdata, 32'h0);
        checkValue("midrst_p1_rdata", bus.p1_rdata, 32'h0);
        checkValue("midrst_p1_ack", 32'(bus.p1_ack), 32'h0);
        checkValue("midrst_busy", 32'(bus.busy), 32'h0);
        bus.p1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
        @(negedge clk);

        $display("[TB] last in-range word write and read back");
        weCount = 0;
        applyStimulus(1'b1, 1'b1, 32'h0003_FFFF, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, 3);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0003_FFFF, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
        checkValue("top_write_strobe_cycles", 32'(weCount), 32'd1);

        repeat (3) @(negedge clk);
        checkValue("p0_queue_drained", 32'(exp0Q.size()), 32'd0);
        checkValue("p1_queue_drained", 32'(exp1Q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
